// File: rtl/lsu_pkg.sv
// Shared width codes, state encoding and access-size helpers for the load/store memory master.
package lsu_pkg;

  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = IDLE,
    S_ACCESS = ACCESS,
    S_RESP   = RESP
  } state_t;

  // Bytes touched by an access of the given width code.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    case (funct3)
      FUNCT3_H, FUNCT3_HU: access_size = 3'd2;
      FUNCT3_W:            access_size = 3'd4;
      default:             access_size = 3'd1;
    endcase
  endfunction

  // Unsigned variants only exist for loads.
  function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
    case (funct3)
      FUNCT3_B, FUNCT3_H, FUNCT3_W: funct3_legal = 1'b1;
      FUNCT3_BU, FUNCT3_HU:         funct3_legal = !we;
      default:                      funct3_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane decode: store write mask, alignment check and load-data extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [3:0]  w_enb,
  output logic        misaligned,
  output logic [31:0] load_data
);

  always_comb begin
    w_enb      = 4'b0000;
    misaligned = 1'b0;
    load_data  = 32'd0;
    case (funct3)
      FUNCT3_B: begin
        w_enb     = we ? 4'b0001 : 4'b0000;
        load_data = {{24{rdata[7]}}, rdata[7:0]};
      end
      FUNCT3_H: begin
        w_enb      = we ? 4'b0011 : 4'b0000;
        misaligned = addr[0];
        load_data  = {{16{rdata[15]}}, rdata[15:0]};
      end
      FUNCT3_W: begin
        w_enb      = we ? 4'b1111 : 4'b0000;
        misaligned = (addr != 2'b00);
        load_data  = rdata;
      end
      FUNCT3_BU: load_data = {24'd0, rdata[7:0]};
      FUNCT3_HU: begin
        misaligned = addr[0];
        load_data  = {16'd0, rdata[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one request at a time, a single-cycle memory access,
// and a held response; illegal requests are answered with an error without touching memory.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [3:0]  mem_w_enb,
  output logic        mem_r_enb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_w_data,
  input  logic [31:0] mem_r_data
);

  localparam int unsigned XW = 33;
  localparam logic [XW-1:0] MAX_ADDR = XW'((64'd1 << ADDR_BITS) - 64'd1);

  state_t        state;
  logic          cap_we;
  logic [2:0]    cap_funct3;

  logic [2:0]    la_funct3;
  logic [3:0]    la_w_enb;
  logic          la_misaligned;
  logic [31:0]   la_load_data;
  logic [XW-1:0] last_byte;
  logic          out_of_range;
  logic          req_legal;

  // In IDLE the lane decoder judges the incoming request; afterwards it extends the captured load.
  assign la_funct3 = (state == S_IDLE) ? req_funct3 : cap_funct3;

  lsu_lane_align u_lane_align (
    .funct3     (la_funct3),
    .we         (req_we),
    .addr       (req_addr[1:0]),
    .rdata      (mem_r_data),
    .w_enb      (la_w_enb),
    .misaligned (la_misaligned),
    .load_data  (la_load_data)
  );

  assign last_byte    = XW'(req_addr) + XW'(access_size(req_funct3)) - XW'(1);
  assign out_of_range = (last_byte > MAX_ADDR);
  assign req_legal    = funct3_legal(req_we, req_funct3) && !la_misaligned && !out_of_range;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      cap_we     <= 1'b0;
      cap_funct3 <= 3'd0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= 32'd0;
      mem_w_enb  <= 4'b0000;
      mem_r_enb  <= 1'b0;
      mem_addr   <= 32'd0;
      mem_w_data <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            cap_we     <= req_we;
            cap_funct3 <= req_funct3;
            req_ready  <= 1'b0;
            if (req_legal) begin
              state      <= S_ACCESS;
              mem_addr   <= req_addr;
              mem_w_data <= req_wdata;
              mem_w_enb  <= la_w_enb;
              mem_r_enb  <= !req_we;
            end else begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'd0;
            end
          end
        end
        // Write commits and read data is captured at the edge that leaves ACCESS.
        S_ACCESS: begin
          state     <= S_RESP;
          mem_w_enb <= 4'b0000;
          mem_r_enb <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= cap_we ? 32'd0 : la_load_data;
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          mem_w_enb <= 4'b0000;
          mem_r_enb <= 1'b0;
        end
      endcase
    end
  end

endmodule
